// File: rtl/one_wire_crc8.sv
// Serial Dallas/Maxim 1-Wire CRC-8 (x^8+x^5+x^4+1, reflected 0x8C) over a
// fixed-length LSB-first frame delimited by the shifter's start_crc level.
module one_wire_crc8 #(
  parameter int unsigned DATA_BITS = 56,
  parameter logic [7:0]  CRC_INIT  = 8'h00,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_crc,
  input  logic       data_stream,
  output logic [7:0] crc_out,
  output logic       crc_valid,
  output logic       busy,
  output logic       crc_abort
);

  typedef enum logic [1:0] {IDLE, ALIGN, SHIFT, DONE} state_t;

  localparam logic [7:0]       POLY     = 8'h8C;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  state_t           state;
  logic             start_q;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       crc;
  logic             fb;
  logic [7:0]       crc_next;

  always_comb begin
    fb       = crc[0] ^ data_stream;
    crc_next = (crc >> 1) ^ (fb ? POLY : '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      cnt       <= '0;
      crc       <= CRC_INIT;
      crc_out   <= '0;
      crc_valid <= 1'b0;
      busy      <= 1'b0;
      crc_abort <= 1'b0;
    end else begin
      start_q   <= start_crc;
      crc_valid <= 1'b0;
      crc_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (start_crc && !start_q) begin
            state <= ALIGN;
            busy  <= 1'b1;
            crc   <= CRC_INIT;
            cnt   <= '0;
          end
        end
        ALIGN: begin
          if (!start_crc) begin
            state     <= IDLE;
            busy      <= 1'b0;
            crc_abort <= 1'b1;
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // An early drop discards the frame; the bit sampled this cycle is not folded in.
          if (!start_crc) begin
            state     <= IDLE;
            busy      <= 1'b0;
            crc_abort <= 1'b1;
          end else begin
            crc <= crc_next;
            if (cnt == LAST_BIT) state <= DONE;
            else                 cnt   <= cnt + 1'b1;
          end
        end
        DONE: begin
          crc_out   <= crc;
          crc_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/one_wire_crc8.md
Name: one_wire_crc8

Overview:
- Serial CRC-8 engine directly downstream of the one-wire UID shifter.
- Consumes the shifter's `start_crc` / `data_stream` pair, LSB-first.
- Accumulates the Dallas/Maxim 1-Wire CRC-8 (x^8+x^5+x^4+1, reflected constant 0x8C, init 0x00) over DATA_BITS bits.
- Presents the 8-bit result with a one-cycle valid strobe, for appending to the ROM code or for checking it.

Parameters:
- DATA_BITS, 56, number of serial bits folded into the CRC per frame.
- CRC_INIT, 8'h00, CRC register value loaded at frame start.
- CNT_W, 8, width of the internal bit counter; must satisfy 2^CNT_W > DATA_BITS.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start_crc  input  1  frame-active level from the shifter; a rising edge starts a frame.
- data_stream  input  1  serial data bit, LSB first, valid one cycle after `start_crc` is first seen high.
- crc_out  output  8  CRC result; holds the last completed value.
- crc_valid  output  1  one-cycle pulse when `crc_out` is updated with a completed CRC.
- busy  output  1  high from frame start until the completion or abort cycle, inclusive.
- crc_abort  output  1  one-cycle pulse when a frame is abandoned because `start_crc` fell early.

Behaviour:
- **Reset** (`rst_n`=0 at a clock edge):
  - state=IDLE, counter=0, CRC register=CRC_INIT, `start_crc` history register=0.
  - `crc_out`=8'h00, `crc_valid`=0, `busy`=0, `crc_abort`=0.
  - Reset takes priority over every other event, including mid-frame; a frame in progress is discarded with no `crc_valid` and no `crc_abort`.
- **Edge detect:** `start_q` registers `start_crc` every cycle. A start is `start_crc`=1 && `start_q`=0. A level held high never retriggers.
- **State machine:**
  - IDLE: on start -> ALIGN, `busy`=1, CRC register=CRC_INIT, counter=0.
  - ALIGN: one cycle, which absorbs the shifter's one-cycle register delay on `data_stream`; -> SHIFT. If `start_crc`=0 here -> abort.
  - SHIFT: each cycle samples `data_stream` as bit b.
    - fb = crc[0]^b; crc <= (crc>>1) ^ (fb ? 8'h8C : 8'h00); counter++.
    - On the cycle the counter reaches DATA_BITS-1 (the last bit is folded in), go -> DONE.
    - If `start_crc`=0 in any SHIFT cycle: the bit is not folded in, -> abort.
  - DONE: `crc_out` <= CRC register, `crc_valid`=1 for this cycle only, `busy`=0 from the next cycle, -> IDLE.
  - Abort: `crc_abort`=1 for one cycle, `busy`=0 next cycle, -> IDLE, `crc_out` unchanged, no `crc_valid`.
- **Latency:** `crc_valid` asserts exactly DATA_BITS+2 cycles after the edge that sampled the start; `crc_out` is valid in that same cycle.
- **Re-arm:** a new frame needs `start_crc` low for at least one cycle after DONE or abort. A start edge that arrives while not in IDLE is ignored; frames are not queued.
- **Bits after the last data bit:** bits present on `data_stream` after the DATA_BITS-th bit (for example the shifter's trailing zero while `start_crc` stays high) are ignored.
- **Output stability:** `crc_out` changes only in DONE or on reset.
- **Width rule:** the counter compares against DATA_BITS-1 and never wraps inside a frame.
- **Self-check property:** with DATA_BITS=64, feeding a full ROM code (UID followed by its own CRC byte) gives `crc_out`=8'h00.

Test Plan:
1. **Maxim example frame:** reset, then start with UID 56'h00_0000_01B8_1C02 streamed LSB first -> `crc_valid` pulses once, 58 cycles after the start edge, with `crc_out`=8'hA2; `busy` high for exactly those cycles.
2. **Self-check:** DATA_BITS=64 instance fed 64'hA200_0000_01B8_1C02 -> `crc_out`=8'h00 with `crc_valid`=1.
3. **Level hold and re-arm:**
   - `start_crc` held high for 200 cycles -> exactly one `crc_valid`.
   - Drop `start_crc` for 1 cycle, raise it, stream all-zero UID -> second `crc_valid` with `crc_out`=8'h00.
4. **Mid-frame abort:** drop `start_crc` after 20 SHIFT cycles -> `crc_abort` pulses once, no `crc_valid`, `crc_out` keeps its previous value (8'hA2 after test 1), `busy`=0 on the next cycle.
5. **Reset mid-frame:** assert `rst_n`=0 for 1 cycle at SHIFT bit 30 -> all outputs 0 on the next cycle, no `crc_valid` or `crc_abort`. A following full frame of the test-1 UID gives 8'hA2.
6. **All-ones UID:** 56'hFF_FFFF_FFFF_FFFF -> `crc_out` equals the bench's golden bit-serial model; also check a start edge during `busy` is ignored (no second frame, no extra `crc_valid`).
